// File: rtl/divider_reconstruct_seq.sv
// Rebuilds n_rec = q*d + r with a shift-add multiplier, LSB first, one bit per cycle, and reports err = n - n_rec.
// Define RECON_SQERR_ACC_EN to add the squared-error accumulator (sq_err_acc, sample_cnt, acc_clr).
module divider_reconstruct_seq #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   n,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   n_rec,
  output logic [2*WIDTH:0]     err,
  output logic                 match
`ifdef RECON_SQERR_ACC_EN
  ,
  input  logic                 acc_clr,
  output logic [ACC_W-1:0]     sq_err_acc,
  output logic [31:0]          sample_cnt
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = PW + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    acc_reg, acc_next;
  logic [PW-1:0]    mcand_reg, mcand_next;
  logic [WIDTH-1:0] qsh_reg, qsh_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [PW-1:0]    n_reg, n_next;
  logic [PW-1:0]    n_rec_reg, n_rec_next;
  logic [EW-1:0]    err_reg, err_next;
  logic             match_reg, match_next;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;

  // Partial product: the shifted multiplicand gated by the current quotient bit.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & qsh_reg[0];
    end
  endgenerate

  assign acc_sum = acc_reg + addend;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    qsh_next   = qsh_reg;
    cnt_next   = cnt_reg;
    n_next     = n_reg;
    n_rec_next = n_rec_reg;
    err_next   = err_reg;
    match_next = match_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          acc_next   = PW'(r);
          mcand_next = PW'(d);
          qsh_next   = q;
          cnt_next   = '0;
          n_next     = n;
          state_next = MUL;
        end
      end
      MUL: begin
        acc_next   = acc_sum;
        mcand_next = mcand_reg << 1;
        qsh_next   = qsh_reg >> 1;
        cnt_next   = cnt_reg + CW'(1);
        // Last bit: results are registered on the same edge that enters DONE.
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
          n_rec_next = acc_sum;
          err_next   = {1'b0, n_reg} - {1'b0, acc_sum};
          match_next = (err_next == '0);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      mcand_reg <= '0;
      qsh_reg   <= '0;
      cnt_reg   <= '0;
      n_reg     <= '0;
      n_rec_reg <= '0;
      err_reg   <= '0;
      match_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      qsh_reg   <= qsh_next;
      cnt_reg   <= cnt_next;
      n_reg     <= n_next;
      n_rec_reg <= n_rec_next;
      err_reg   <= err_next;
      match_reg <= match_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign n_rec     = n_rec_reg;
  assign err       = err_reg;
  assign match     = match_reg;

`ifdef RECON_SQERR_ACC_EN
  logic signed [2*EW-1:0] err_ext;
  logic signed [2*EW-1:0] sq_err;
  logic [ACC_W-1:0]       sq_err_acc_reg;
  logic [31:0]            sample_cnt_reg;

  // Sign-extend before squaring so the product of a negative error is its true square.
  assign err_ext = {{EW{err_reg[EW-1]}}, err_reg};
  assign sq_err  = err_ext * err_ext;

  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      sq_err_acc_reg <= '0;
      sample_cnt_reg <= '0;
    end else if (out_valid && out_ready) begin
      sq_err_acc_reg <= sq_err_acc_reg + ACC_W'($unsigned(sq_err));
      sample_cnt_reg <= sample_cnt_reg + 32'd1;
    end
  end

  assign sq_err_acc = sq_err_acc_reg;
  assign sample_cnt = sample_cnt_reg;
`endif

endmodule

// File: tb/tb_divider_reconstruct_seq.sv
// Bench for divider_reconstruct_seq: directed vector table, reset/backpressure sequences, and random operands vs. an arithmetic model.
module tb_divider_reconstruct_seq;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int EW = PW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] n;
  logic [W-1:0]  d, q, r;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] n_rec;
  logic [EW-1:0] err;
  logic          match;
`ifdef RECON_SQERR_ACC_EN
  logic          acc_clr;
  logic [47:0]   sq_err_acc;
  logic [31:0]   sample_cnt;
`endif

  always #5 clk = ~clk;

  divider_reconstruct_seq #(.WIDTH(W), .ACC_W(48)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n         (n),
    .d         (d),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_rec     (n_rec),
    .err       (err),
    .match     (match)
`ifdef RECON_SQERR_ACC_EN
    ,
    .acc_clr   (acc_clr),
    .sq_err_acc(sq_err_acc),
    .sample_cnt(sample_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit clr_on_hs = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [PW+EW:0] model(input logic [PW-1:0] nn, input logic [W-1:0] dd,
                                            input logic [W-1:0] qq, input logic [W-1:0] rr);
    int unsigned rec;
    int          e;
    rec = int'(qq) * int'(dd) + int'(rr);
    e   = int'(nn) - int'(rec);
    return {(e == 0), EW'(e), PW'(rec)};
  endfunction

  // One full transaction: accept, check latency, hold out_ready low for `hold` cycles, then consume.
  task automatic run_op(input logic [PW-1:0] nn, input logic [W-1:0] dd, input logic [W-1:0] qq,
                        input logic [W-1:0] rr, input int hold,
                        output logic [PW-1:0] g_nrec, output logic [EW-1:0] g_err, output logic g_match);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    n = nn; d = dd; q = qq; r = rr;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = PW'($urandom); d = W'($urandom); q = W'($urandom); r = W'($urandom);
    check("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(W));
    g_nrec  = n_rec;
    g_err   = err;
    g_match = match;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_n_rec", 64'(n_rec), 64'(g_nrec));
      check("hold_err", 64'(err), 64'(g_err));
    end
    out_ready = 1'b1;
`ifdef RECON_SQERR_ACC_EN
    acc_clr = clr_on_hs;
`endif
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
`ifdef RECON_SQERR_ACC_EN
    acc_clr = 1'b0;
`endif
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    $display("op n=%0d d=%0d q=%0d r=%0d -> n_rec=%0d err=0x%0h match=%0d lat=%0d",
             nn, dd, qq, rr, g_nrec, g_err, g_match, lat);
  endtask

  typedef struct {
    logic [PW-1:0] n;
    logic [W-1:0]  d, q, r;
    logic [PW-1:0] e_nrec;
    logic [EW-1:0] e_err;
    logic          e_match;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [PW-1:0]   g_nrec;
    logic [EW-1:0]   g_err;
    logic            g_match;
    logic [PW+EW:0]  exp_v;
    logic [PW-1:0]   rn;
    logic [W-1:0]    rd, rq, rr;

    vecs[0] = '{16'd1000,  8'd10,  8'd100, 8'd0,   16'd1000,  17'd0,      1'b1};
    vecs[1] = '{16'd100,   8'd7,   8'd14,  8'd3,   16'd101,   17'h1FFFF,  1'b0};
    vecs[2] = '{16'd65535, 8'd255, 8'd255, 8'd255, 16'd65280, 17'd255,    1'b0};
    vecs[3] = '{16'd40,    8'd0,   8'd255, 8'd5,   16'd5,     17'd35,     1'b0};
    vecs[4] = '{16'd0,     8'd0,   8'd0,   8'd0,   16'd0,     17'd0,      1'b1};
    vecs[5] = '{16'd0,     8'd255, 8'd255, 8'd255, 16'd65280, 17'h10100,  1'b0};
    vecs[6] = '{16'd7,     8'd3,   8'd0,   8'd7,   16'd7,     17'd0,      1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n = '0; d = '0; q = '0; r = '0;
`ifdef RECON_SQERR_ACC_EN
    acc_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_n_rec", 64'(n_rec), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_match", 64'(match), 64'd0);
    rst = 1'b0;

`ifdef RECON_SQERR_ACC_EN
    run_op(vecs[1].n, vecs[1].d, vecs[1].q, vecs[1].r, 0, g_nrec, g_err, g_match);
    run_op(vecs[2].n, vecs[2].d, vecs[2].q, vecs[2].r, 0, g_nrec, g_err, g_match);
    check("sq_err_acc", 64'(sq_err_acc), 64'd65026);
    check("sample_cnt", 64'(sample_cnt), 64'd2);
    clr_on_hs = 1'b1;
    run_op(vecs[0].n, vecs[0].d, vecs[0].q, vecs[0].r, 0, g_nrec, g_err, g_match);
    clr_on_hs = 1'b0;
    check("sq_err_acc_clr", 64'(sq_err_acc), 64'd0);
    check("sample_cnt_clr", 64'(sample_cnt), 64'd0);
`endif

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, (i == 2) ? 5 : i % 2, g_nrec, g_err, g_match);
      check($sformatf("vec%0d_n_rec", i), 64'(g_nrec), 64'(vecs[i].e_nrec));
      check($sformatf("vec%0d_err", i), 64'(g_err), 64'(vecs[i].e_err));
      check($sformatf("vec%0d_match", i), 64'(g_match), 64'(vecs[i].e_match));
    end

    // Reset during the third multiply cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    n = 16'd100; d = 8'd7; q = 8'd14; r = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mulrst_in_ready", 64'(in_ready), 64'd1);
    check("mulrst_out_valid", 64'(out_valid), 64'd0);
    check("mulrst_n_rec", 64'(n_rec), 64'd0);
    check("mulrst_err", 64'(err), 64'd0);
    $display("op reset during MUL: in_ready=%0d out_valid=%0d n_rec=%0d", in_ready, out_valid, n_rec);
    run_op(vecs[0].n, vecs[0].d, vecs[0].q, vecs[0].r, 0, g_nrec, g_err, g_match);
    check("after_rst_n_rec", 64'(g_nrec), 64'd1000);
    check("after_rst_match", 64'(g_match), 64'd1);

    // Reset while a result waits in DONE drops it.
    @(negedge clk);
    in_valid = 1'b1;
    n = 16'd40; d = 8'd0; q = 8'd255; r = 8'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W + 2) @(posedge clk);
    @(negedge clk);
    check("done_wait_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check("donerst_out_valid", 64'(out_valid), 64'd0);
    check("donerst_n_rec", 64'(n_rec), 64'd0);
    check("donerst_in_ready", 64'(in_ready), 64'd1);
    $display("op reset during DONE: out_valid=%0d n_rec=%0d", out_valid, n_rec);

    for (int k = 0; k < 40; k++) begin
      rd = W'($urandom);
      rq = W'($urandom);
      rr = W'($urandom);
      if ($urandom_range(0, 1) == 0) rn = PW'(int'(rq) * int'(rd) + int'(rr));
      else rn = PW'($urandom);
      exp_v = model(rn, rd, rq, rr);
      run_op(rn, rd, rq, rr, int'($urandom_range(0, 3)), g_nrec, g_err, g_match);
      check("rand_n_rec", 64'(g_nrec), 64'(exp_v[PW-1:0]));
      check("rand_err", 64'(g_err), 64'(exp_v[PW+EW-1:PW]));
      check("rand_match", 64'(g_match), 64'(exp_v[PW+EW]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
